// File: rtl/sonata_switch_debounce.sv
// Sonata switch conditioning: 2-flop synchroniser, per-bit stability debounce, polarity fix.
// Define SONATA_SWITCH_IRQ_EN to enable the sticky irq_o change flag; otherwise irq_o is 0.
module sonata_switch_debounce #(
    parameter int unsigned Width          = 13,
    parameter int unsigned DebounceCycles = 250000,
    parameter bit          ActiveLow      = 1'b1
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] sw_o,
    output logic             changed_o,
    input  logic             irq_clear_i,
    output logic             irq_o
);

    localparam int unsigned      CntW     = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(DebounceCycles - 1);
    localparam logic [Width-1:0] OffLevel = ActiveLow ? {Width{1'b1}} : {Width{1'b0}};

    logic [Width-1:0] sync1_q, sync1_d;
    logic [Width-1:0] sync2_q, sync2_d;
    logic [Width-1:0] stable_q, stable_d;
    logic [CntW-1:0]  cnt_q [Width];
    logic [CntW-1:0]  cnt_d [Width];
    logic             changed_q, changed_d;

    // NOTE: every _d gets its default before any branch, so no latch can be inferred.
    always_comb begin
        sync1_d  = raw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < int'(Width); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
        changed_d = |(stable_d ^ stable_q);
    end

    // NOTE: state updates use non-blocking <= only; the counters are real state and are cleared on reset.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            sync1_q   <= OffLevel;
            sync2_q   <= OffLevel;
            stable_q  <= OffLevel;
            changed_q <= 1'b0;
            for (int i = 0; i < int'(Width); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SONATA_SWITCH_IRQ_EN
    logic irq_q, irq_d;

    // A pending change beats a simultaneous clear so no event is lost.
    always_comb begin
        irq_d = irq_q;
        if (changed_q) begin
            irq_d = 1'b1;
        end else if (irq_clear_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_clear;
    assign unused_irq_clear = irq_clear_i;
    assign irq_o            = 1'b0;
`endif

    assign sw_o      = ActiveLow ? ~stable_q : stable_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_sonata_switch_debounce.sv
// Self-checking bench for sonata_switch_debounce: directed scenarios plus randomized traffic
// compared against a sliding-window reference model of the debounce rule.
`timescale 1ns/1ps
module tb_sonata_switch_debounce;

    localparam int W   = 13;
    localparam int DEB = 8;
    localparam logic [W-1:0] OFF = {W{1'b1}};
`ifdef SONATA_SWITCH_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] raw;
    logic         irq_clear;
    logic [W-1:0] sw;
    logic         changed;
    logic         irq;

    logic [3:0]   raw1;
    logic         clear1;
    logic [3:0]   sw1;
    logic         changed1;
    logic         irq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sonata_switch_debounce #(.Width(W), .DebounceCycles(DEB), .ActiveLow(1'b1)) dut (
        .clk_sys_i  (clk),
        .rst_sys_ni (rst_n),
        .raw_i      (raw),
        .sw_o       (sw),
        .changed_o  (changed),
        .irq_clear_i(irq_clear),
        .irq_o      (irq)
    );

    sonata_switch_debounce #(.Width(4), .DebounceCycles(1), .ActiveLow(1'b0)) dut_min (
        .clk_sys_i  (clk),
        .rst_sys_ni (rst_n),
        .raw_i      (raw1),
        .sw_o       (sw1),
        .changed_o  (changed1),
        .irq_clear_i(clear1),
        .irq_o      (irq1)
    );

    // Reference model: a bit is accepted once the raw level seen two edges earlier has held
    // the same value, different from the accepted one, for DEB consecutive samples with no reset.
    logic [W-1:0] m_stable = OFF;
    bit           m_changed = 1'b0;
    bit           m_irq = 1'b0;
    logic [W-1:0] raw_h[$];
    bit           rst_h[$];

    always @(posedge clk) begin
        int n;
        bit ok;
        bit same;
        logic [W-1:0] flips;
        flips = '0;
        n = raw_h.size();
        if (!rst_n) begin
            m_stable  = OFF;
            m_changed = 1'b0;
            m_irq     = 1'b0;
        end else begin
            if (n >= DEB + 1) begin
                ok = 1'b1;
                for (int k = n - 1 - DEB; k < n; k++) if (!rst_h[k]) ok = 1'b0;
                if (ok) begin
                    for (int b = 0; b < W; b++) begin
                        same = 1'b1;
                        for (int k = n - 1 - DEB; k <= n - 2; k++)
                            if (raw_h[k][b] !== raw_h[n-2][b]) same = 1'b0;
                        if (same && raw_h[n-2][b] !== m_stable[b]) flips[b] = 1'b1;
                    end
                end
            end
            if (IrqEn) begin
                if (m_changed) m_irq = 1'b1;
                else if (irq_clear) m_irq = 1'b0;
            end
            m_stable  = m_stable ^ flips;
            m_changed = |flips;
        end
        raw_h.push_back(raw);
        rst_h.push_back(rst_n);
        if (raw_h.size() > DEB + 4) begin
            void'(raw_h.pop_front());
            void'(rst_h.pop_front());
        end
    end

    function automatic logic [W+1:0] exp_vec();
        return {~m_stable, m_changed, m_irq};
    endfunction

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int rise = -1;
        int pulses = 0;
        rst_n = 1'b0; raw = '0; irq_clear = 1'b0; raw1 = '0; clear1 = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if (sw !== '0 || changed !== 1'b0 || irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold e=%0d got sw=%h ch=%b irq=%b expected 0/0/0", e, sw, changed, irq);
            end
        end
        rst_n = 1'b1;
        for (int e = 0; e < DEB + 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({sw, changed, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_release e=%0d got %h expected %h", e, {sw, changed, irq}, exp_vec());
            end
            if (sw == 13'h1FFF && rise < 0) rise = e;
            if (changed === 1'b1) pulses++;
        end
        checks++;
        if (rise != DEB + 1) begin
            errors++;
            $display("FAIL reset_latency got edge %0d expected edge %0d", rise, DEB + 1);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL reset_pulse_count got %0d expected 1", pulses);
        end
    endtask

    task automatic test_clean_press();
        int rise = -1;
        int pulses = 0;
        raw = OFF;
        run(DEB + 4);
        raw[0] = 1'b0;
        for (int e = 0; e < DEB + 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({sw, changed, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL clean_press e=%0d got %h expected %h", e, {sw, changed, irq}, exp_vec());
            end
            if (sw[0] === 1'b1 && rise < 0) rise = e;
            if (changed === 1'b1) pulses++;
        end
        checks++;
        if (rise != DEB + 1 || pulses != 1 || sw !== 13'h0001) begin
            errors++;
            $display("FAIL clean_press_summary got rise=%0d pulses=%0d sw=%h expected rise=%0d pulses=1 sw=0001",
                     rise, pulses, sw, DEB + 1);
        end
    endtask

    task automatic test_bounce();
        int lvl[6] = '{0, 1, 0, 1, 0, 1};
        int len[6] = '{7, 2, 7, 12, 8, 14};
        int pulses = 0;
        bit seen = 1'b0;
        raw = OFF;
        run(DEB + 4);
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                raw[3] = lvl[s][0];
                @(posedge clk); #1;
                checks++;
                if ({sw, changed, irq} !== exp_vec()) begin
                    errors++;
                    $display("FAIL bounce s=%0d c=%0d got %h expected %h", s, c, {sw, changed, irq}, exp_vec());
                end
                if (s < 4) begin
                    checks++;
                    if (sw[3] !== 1'b0 || changed !== 1'b0) begin
                        errors++;
                        $display("FAIL bounce_reject s=%0d c=%0d got sw3=%b ch=%b expected 0/0", s, c, sw[3], changed);
                    end
                end else begin
                    if (changed === 1'b1) pulses++;
                    if (sw[3] === 1'b1) seen = 1'b1;
                end
            end
        end
        checks++;
        if (!seen || pulses != 2) begin
            errors++;
            $display("FAIL bounce_accept got seen=%0b pulses=%0d expected seen=1 pulses=2", seen, pulses);
        end
    endtask

    task automatic test_simultaneous();
        int rise = -1;
        int pulses = 0;
        raw = OFF ^ 13'h1FE0;
        for (int e = 0; e < DEB + 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({sw, changed, irq} !== exp_vec() || (sw[12:5] !== 8'h00 && sw[12:5] !== 8'hFF)) begin
                errors++;
                $display("FAIL simultaneous e=%0d got %h expected %h", e, {sw, changed, irq}, exp_vec());
            end
            if (sw[12:5] === 8'hFF && rise < 0) rise = e;
            if (changed === 1'b1) pulses++;
        end
        checks++;
        if (rise != DEB + 1 || pulses != 1) begin
            errors++;
            $display("FAIL simultaneous_summary got rise=%0d pulses=%0d expected rise=%0d pulses=1", rise, pulses, DEB + 1);
        end
        raw = OFF;
        run(DEB + 4);
    endtask

    task automatic test_reset_mid_count();
        int rise = -1;
        int pulses = 0;
        raw = OFF;
        raw[1] = 1'b0;
        for (int e = 0; e < 9; e++) begin
            if (e == 7) rst_n = 1'b0;
            @(posedge clk); #1;
            checks++;
            if ({sw, changed, irq} !== exp_vec() || sw[1] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_count e=%0d got %h expected %h", e, {sw, changed, irq}, exp_vec());
            end
        end
        rst_n = 1'b1;
        for (int e = 0; e < DEB + 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({sw, changed, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_release e=%0d got %h expected %h", e, {sw, changed, irq}, exp_vec());
            end
            if (sw[1] === 1'b1 && rise < 0) rise = e;
            if (changed === 1'b1) pulses++;
        end
        checks++;
        if (rise != DEB + 1 || pulses != 1) begin
            errors++;
            $display("FAIL reset_mid_latency got rise=%0d pulses=%0d expected rise=%0d pulses=1", rise, pulses, DEB + 1);
        end
        raw = OFF;
        run(DEB + 4);
    endtask

    task automatic test_irq();
        irq_clear = 1'b1;
        run(1);
        irq_clear = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_initial_clear got %b expected 0", irq);
        end
        raw[2] = 1'b0;
        for (int e = 0; e < DEB + 8; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({sw, changed, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL irq_press e=%0d got %h expected %h", e, {sw, changed, irq}, exp_vec());
            end
        end
        checks++;
        if (irq !== IrqEn) begin
            errors++;
            $display("FAIL irq_sticky got %b expected %b", irq, IrqEn);
        end
        raw[2] = 1'b1;
        run(DEB + 2);
        checks++;
        if (changed !== 1'b1) begin
            errors++;
            $display("FAIL irq_release_pulse got %b expected 1", changed);
        end
        irq_clear = 1'b1;
        run(1);
        irq_clear = 1'b0;
        checks++;
        if (irq !== IrqEn || {sw, changed, irq} !== exp_vec()) begin
            errors++;
            $display("FAIL irq_set_wins got irq=%b expected %b", irq, IrqEn);
        end
        run(2);
        irq_clear = 1'b1;
        run(1);
        irq_clear = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear_alone got %b expected 0", irq);
        end
    endtask

    task automatic test_min_debounce();
        logic [3:0] drv   [9] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5};
        logic [3:0] exp_s [9] = '{4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 4'h5, 4'h5};
        logic       exp_c [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++) begin
            raw1 = drv[k];
            @(posedge clk); #1;
            checks++;
            if (sw1 !== exp_s[k] || changed1 !== exp_c[k]) begin
                errors++;
                $display("FAIL min_debounce edge=%0d got sw=%h ch=%b expected sw=%h ch=%b",
                         k, sw1, changed1, exp_s[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] base = OFF;
        int pulses = 0;
        for (int e = 0; e < 2000; e++) begin
            if ($urandom_range(0, 15) == 0) base = W'($urandom);
            raw = base;
            if ($urandom_range(0, 3) == 0) raw[$urandom_range(0, W - 1)] ^= 1'b1;
            rst_n     = ($urandom_range(0, 249) != 0);
            irq_clear = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
            checks++;
            if ({sw, changed, irq} !== exp_vec()) begin
                errors++;
                $display("FAIL random e=%0d got %h expected %h", e, {sw, changed, irq}, exp_vec());
            end
            if (changed === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        irq_clear = 1'b0;
        checks++;
        if (pulses == 0) begin
            errors++;
            $display("FAIL random_activity got %0d change pulses expected at least 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_irq();
        test_min_debounce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
